// File: rtl/adc_dc_rssi_frontend_pkg.sv
// adc_dc_rssi_frontend_pkg: settings addresses, control bit positions and helpers for the ADC front ends.
package adc_dc_rssi_frontend_pkg;

    localparam logic [6:0] FR_ADC_DCCTRL_0 = 7'd10;
    localparam logic [6:0] FR_ADC_OFFSET_0 = 7'd11;
    localparam logic [6:0] FR_ADC_DCCTRL_1 = 7'd12;
    localparam logic [6:0] FR_ADC_OFFSET_1 = 7'd13;
    localparam logic [6:0] FR_ADC_DCCTRL_2 = 7'd14;
    localparam logic [6:0] FR_ADC_OFFSET_2 = 7'd15;
    localparam logic [6:0] FR_ADC_DCCTRL_3 = 7'd16;
    localparam logic [6:0] FR_ADC_OFFSET_3 = 7'd17;

    localparam int DC_EN_BIT     = 0;
    localparam int DC_FREEZE_BIT = 1;

    typedef struct packed {
        logic dc_freeze;
        logic dc_en;
    } dc_ctrl_t;

    // Clamp a 17-bit signed difference into the 16-bit signed range.
    function automatic logic [15:0] sat17(input logic [16:0] v);
        return (v[16] != v[15]) ? (v[16] ? 16'h8000 : 16'h7FFF) : v[15:0];
    endfunction

endpackage

// File: rtl/adc_dc_rssi_frontend_rssi_window.sv
// adc_dc_rssi_frontend_rssi_window: windowed mean magnitude and over-range count of a 12-bit sample stream.
module adc_dc_rssi_frontend_rssi_window #(
    parameter int WINDOW_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en_i,
    input  logic [11:0] sample_i,
    output logic [31:0] rssi_o,
    output logic        rssi_strobe_o
);

    localparam int SW = 12 + WINDOW_LOG2;

    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [SW-1:0]          sum_q, sum_d, sum_all;
    logic [15:0]            ovr_q, ovr_d, ovr_all;
    logic [31:0]            rssi_q, rssi_d;
    logic                   strobe_q, strobe_d;
    logic [11:0]            mag;
    logic                   is_ovr, last;

    // The closing sample is folded into the published result so nothing straddles a boundary.
    always_comb begin
        mag      = sample_i[11] ? 12'(-sample_i) : sample_i;
        is_ovr   = (sample_i == 12'h7FF) || (sample_i == 12'h800);
        sum_all  = sum_q + SW'(mag);
        ovr_all  = (is_ovr && ovr_q != 16'hFFFF) ? ovr_q + 16'd1 : ovr_q;
        last     = &cnt_q;
        cnt_d    = en_i ? cnt_q + 1'b1 : cnt_q;
        sum_d    = en_i ? (last ? '0 : sum_all) : sum_q;
        ovr_d    = en_i ? (last ? '0 : ovr_all) : ovr_q;
        rssi_d   = (en_i && last) ? {ovr_all, 16'(sum_all >> WINDOW_LOG2)} : rssi_q;
        strobe_d = en_i && last;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sum_q    <= '0;
            ovr_q    <= '0;
            rssi_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            ovr_q    <= ovr_d;
            rssi_q   <= rssi_d;
            strobe_q <= strobe_d;
        end
    end

    assign rssi_o        = rssi_q;
    assign rssi_strobe_o = strobe_q;

endmodule

// File: rtl/adc_dc_rssi_frontend.sv
// adc_dc_rssi_frontend: registers a 12-bit ADC word, removes DC with a leaky integrator
// and measures windowed RSSI / over-range for readback.
module adc_dc_rssi_frontend
    import adc_dc_rssi_frontend_pkg::*;
#(
    parameter logic [6:0] SR_ADDR     = FR_ADC_DCCTRL_0,
    parameter int         WINDOW_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic [11:0] rx_adc,
    output logic [15:0] adc_out,
    output logic [31:0] rssi,
    output logic        rssi_strobe
);

    dc_ctrl_t    ctrl_q, ctrl_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] s1_q, s1_d, out_q, out_d, dc_sat;
    logic        vld_q;
    logic        ctrl_wr, off_wr;
    logic        unused_data;

    assign unused_data = ^serial_data[31:16];

    // A manual offset load takes priority over every integrator mode, even while disabled.
    always_comb begin
        ctrl_wr = serial_strobe && serial_addr == SR_ADDR;
        off_wr  = serial_strobe && serial_addr == SR_ADDR + 7'd1;
        ctrl_d  = ctrl_wr ? '{dc_freeze: serial_data[DC_FREEZE_BIT], dc_en: serial_data[DC_EN_BIT]} : ctrl_q;
        s1_d    = {rx_adc, 4'b0};
        dc_sat  = sat17({s1_q[15], s1_q} - {acc_q[31], acc_q[31:16]});
        out_d   = !enable ? '0 : ctrl_q.dc_en ? dc_sat : s1_q;
        acc_d   = off_wr ? {serial_data[15:0], 16'b0}
                : (!enable || (ctrl_q.dc_en && ctrl_q.dc_freeze)) ? acc_q
                : !ctrl_q.dc_en ? '0
                : acc_q + {{16{dc_sat[15]}}, dc_sat};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            acc_q  <= '0;
            s1_q   <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            acc_q  <= acc_d;
            s1_q   <= s1_d;
            out_q  <= out_d;
            vld_q  <= 1'b1;
        end
    end

    assign adc_out = out_q;

    // vld_q keeps the reset-cleared input register out of the first window.
    adc_dc_rssi_frontend_rssi_window #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_rssi (
        .clock        (clock),
        .reset        (reset),
        .en_i         (enable && vld_q),
        .sample_i     (s1_q[15:4]),
        .rssi_o       (rssi),
        .rssi_strobe_o(rssi_strobe)
    );

endmodule

// File: tb/tb_adc_dc_rssi_frontend.sv
// tb_adc_dc_rssi_frontend: randomized and directed checks of the ADC front end against an arithmetic model.
`timescale 1ns/1ps
module tb_adc_dc_rssi_frontend;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic [11:0] rx_adc = '0;
    logic [15:0] adc_out;
    logic [31:0] rssi;
    logic        rssi_strobe;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    adc_dc_rssi_frontend dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .serial_addr  (serial_addr),
        .serial_data  (serial_data),
        .serial_strobe(serial_strobe),
        .rx_adc       (rx_adc),
        .adc_out      (adc_out),
        .rssi         (rssi),
        .rssi_strobe  (rssi_strobe)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic on whole samples and window totals.
    logic [1:0]  m_ctrl = '0;
    logic [31:0] m_acc = '0;
    int          m_s1 = 0, m_cnt = 0, m_sum = 0, m_ovr = 0;
    int          m_x, m_off, m_diff, m_sat;
    bit          m_vld = 0;
    logic [15:0] e_adc = '0;
    logic [31:0] e_rssi = '0;
    logic        e_stb = 1'b0;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_ctrl = '0; m_acc = '0; m_s1 = 0; m_vld = 0;
            m_cnt = 0; m_sum = 0; m_ovr = 0;
            e_adc = '0; e_rssi = '0; e_stb = 1'b0;
        end else begin
            m_x    = m_s1 * 16;
            m_off  = int'(signed'(m_acc[31:16]));
            m_diff = m_x - m_off;
            m_sat  = m_diff > 32767 ? 32767 : (m_diff < -32768 ? -32768 : m_diff);
            e_adc  = !enable ? 16'h0 : (m_ctrl[0] ? 16'(m_sat) : 16'(m_x));
            if (serial_strobe && serial_addr == 7'd11) m_acc = {serial_data[15:0], 16'h0};
            else if (enable && !m_ctrl[0]) m_acc = '0;
            else if (enable && !m_ctrl[1]) m_acc = m_acc + 32'(m_sat);
            e_stb = 1'b0;
            if (enable && m_vld) begin
                m_sum += (m_s1 < 0) ? -m_s1 : m_s1;
                m_ovr += (m_s1 == 2047 || m_s1 == -2048) ? 1 : 0;
                m_cnt++;
                if (m_cnt == 1024) begin
                    e_rssi = {16'(m_ovr > 65535 ? 65535 : m_ovr), 16'(m_sum / 1024)};
                    e_stb  = 1'b1;
                    m_cnt = 0; m_sum = 0; m_ovr = 0;
                end
            end
            if (serial_strobe && serial_addr == 7'd10) m_ctrl = serial_data[1:0];
            m_s1  = int'(signed'(rx_adc));
            m_vld = 1;
        end
    end

    initial forever begin
        @(negedge clock);
        check("model_adc_out", {16'h0, adc_out}, {16'h0, e_adc});
        check("model_rssi", rssi, e_rssi);
        check("model_rssi_strobe", {31'h0, rssi_strobe}, {31'h0, e_stb});
    end

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        serial_addr = a; serial_data = d; serial_strobe = 1'b1;
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    task automatic wait_stb(input int max, output int n);
        n = 0;
        while (!rssi_strobe && n < max) begin
            @(negedge clock);
            n++;
        end
        if (!rssi_strobe) begin
            total++; bad++;
            $display("FAIL strobe_timeout: no rssi_strobe within %0d cycles", max);
        end
    endtask

    int   n, n_dis;
    bit   nonmono;
    logic [15:0] prev;

    initial begin
        rx_adc = 12'h100;
        repeat (3) @(negedge clock);
        check("reset_adc_out", {16'h0, adc_out}, 32'h0);
        check("reset_rssi", rssi, 32'h0);
        check("reset_strobe", {31'h0, rssi_strobe}, 32'h0);
        reset = 1'b0;
        wait_stb(1100, n);
        check("win1_len", n, 1025);
        check("win1_rssi", rssi, 32'h0000_0100);
        check("passthru_adc_out", {16'h0, adc_out}, 32'h0000_1000);

        wr(7'd10, 32'h1);
        prev = adc_out; nonmono = 0;
        repeat (20000) begin
            @(negedge clock);
            if ($signed(adc_out) > $signed(prev)) nonmono = 1;
            prev = adc_out;
        end
        check("decay_monotonic", {31'h0, nonmono}, 32'h0);
        check("decay_progress", {31'h0, adc_out < 16'h0D00}, 32'h1);

        wr(7'd10, 32'h3);
        wr(7'd11, 32'h1000);
        repeat (4) @(negedge clock);
        check("offset_load_zero", {16'h0, adc_out}, 32'h0);
        repeat (10) @(negedge clock);
        check("offset_hold_zero", {16'h0, adc_out}, 32'h0);

        rx_adc = 12'h7FF;
        wr(7'd11, 32'h8000);
        repeat (4) @(negedge clock);
        check("sat_pos", {16'h0, adc_out}, 32'h0000_7FFF);
        rx_adc = 12'h800;
        wr(7'd11, 32'h7FFF);
        repeat (4) @(negedge clock);
        check("sat_neg", {16'h0, adc_out}, 32'h0000_8000);

        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 31);
            rx_adc = (r < 3) ? 12'h7FF : (r < 6) ? 12'h800 : 12'($urandom);
            enable = $urandom_range(0, 15) != 0;
            serial_strobe = $urandom_range(0, 19) == 0;
            r = $urandom_range(0, 3);
            serial_addr = (r == 0) ? 7'd10 : (r == 1) ? 7'd11 : 7'($urandom);
            serial_data = $urandom;
            @(negedge clock);
        end
        serial_strobe = 1'b0; enable = 1'b1;

        rx_adc = 12'h0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst_adc_out", {16'h0, adc_out}, 32'h0);
        check("async_rst_rssi", rssi, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        rx_adc = 12'h800;
        repeat (5) @(negedge clock);
        rx_adc = 12'h7FF;
        repeat (3) @(negedge clock);
        rx_adc = 12'h0;
        wait_stb(1100, n);
        check("ovr_rssi", rssi, 32'h0008_000F);

        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rx_adc = 12'h100;
        repeat (300) @(negedge clock);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        check("disabled_adc_out", {16'h0, adc_out}, 32'h0);
        repeat (98) @(negedge clock);
        enable = 1'b1;
        wait_stb(1100, n_dis);
        check("gap_win_len", 400 + n_dis, 1125);
        check("gap_win_rssi", rssi, 32'h0000_0100);
        repeat (200) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midwin_rst_rssi", rssi, 32'h0);
        check("midwin_rst_adc_out", {16'h0, adc_out}, 32'h0);
        check("midwin_rst_strobe", {31'h0, rssi_strobe}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_dc_rssi_frontend.md
Name: adc_dc_rssi_frontend

Overview:
- Per-ADC input conditioning stage, one instance per 12-bit ADC input. Sits directly upstream of the DDC input mux and the rx_chain.
- Registers the raw ADC word, widens it to 16 bits and removes DC with a settings-controlled leaky integrator.
- Measures windowed RSSI and over-range counts. The RSSI word is exported for serial_io readback.

Parameters:
- SR_ADDR, 7'd10, serial settings address for control. SR_ADDR+1 is the manual offset load address.
- WINDOW_LOG2, 10, log2 of the RSSI averaging window in samples (range 4..16).

Ports:
- clock  input  1  master clock (clk64 domain).
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  stage enable. Low freezes all accumulators and forces adc_out to 0.
- serial_addr  input  7  settings bus address.
- serial_data  input  32  settings bus data.
- serial_strobe  input  1  settings bus write strobe, one cycle.
- rx_adc  input  12  raw two's-complement ADC sample, one per clock.
- adc_out  output  16  DC-corrected sample, to the DDC input mux.
- rssi  output  32  [31:16] over-range count of the last window, [15:0] mean magnitude of the last window.
- rssi_strobe  output  1  one-cycle pulse when rssi updates.

Behaviour:
- Reset values:
  - adc_out=0, rssi=0, rssi_strobe=0.
  - Control register=0, integrator acc=0, window counter=0, sum=0, overrange count=0, input register=0.
- Control register (write at SR_ADDR): bit0 dc_en, bit1 dc_freeze. Other bits are ignored.
- Manual offset load (write at SR_ADDR+1): acc[31:16]<=serial_data[15:0], acc[15:0]<=0.
  - Takes effect the cycle after the strobe.
  - Overrides integration in that cycle.
- Stage 1 (every clock): s1 <= {rx_adc,4'b0}, which gives 16-bit left-justified signed.
- Stage 2: offset = acc[31:16].
  - diff = sign-extended 17-bit s1 - offset.
  - adc_out <= diff saturated to [-32768, 32767].
  - Latency from rx_adc to adc_out is 2 clocks.
- Integrator update (each clock, enable=1):
  - dc_en=0: acc <= 0 and adc_out = s1 unmodified. A manual load is still accepted but cleared the next cycle unless dc_en=1.
  - dc_en=1 and dc_freeze=0: acc <= acc + sign-extended saturated diff, 32-bit wrap. Time constant is 2^16 samples.
  - dc_en=1 and dc_freeze=1: acc holds.
- RSSI window: mag = |rx_adc registered| as a 12-bit unsigned value. -2048 maps to 2048.
  - sum accumulates mag over 2^WINDOW_LOG2 samples. Sum width is 12+WINDOW_LOG2 bits.
  - ovr_cnt increments when the registered sample equals 2047 or -2048. It saturates at 16'hFFFF.
  - On the last sample of a window (counter = 2^WINDOW_LOG2-1) the counter wraps to 0 and, on the next clock:
    - rssi[15:0] <= (sum+mag) >> WINDOW_LOG2.
    - rssi[31:16] <= ovr_cnt, including the current sample.
    - sum and ovr_cnt restart from 0.
    - rssi_strobe pulses for one cycle.
- Window boundary: samples are never dropped or double-counted.
- enable=0:
  - adc_out <= 0.
  - acc, sum, ovr_cnt and the window counter hold; rssi holds; rssi_strobe=0.
  - Settings writes are still accepted.
- Simultaneous manual load and integration: the load wins.
- Reset asserted mid-window: everything clears immediately and asynchronously. The first window after release is full length.
- Settings writes to other addresses have no effect.

Decomposition:
- Shared package/include (fpga_regs_standard): FR_ADC_DCCTRL_0..3 and FR_ADC_OFFSET_0..3 address constants, and the control bit positions DC_EN_BIT=0 and DC_FREEZE_BIT=1.
- One natural sub-module: rssi_window (magnitude, window counter, sum and over-range count, rssi/rssi_strobe outputs). It is parameterised by WINDOW_LOG2.
- The DC path and the setting_reg instance stay in the top module.

Test Plan:
- Reset, then constant rx_adc=12'h100 with dc_en=0: adc_out=16'h1000 from cycle 2 onward; rssi_strobe first pulses after 1024 samples with rssi=32'h0000_0100.
- Write control=1, constant rx_adc=12'h100: adc_out decays monotonically toward 0; |adc_out|<16 after 2^20 clocks; acc[31:16] reaches about 16'h1000.
- Manual offset load of 16'h1000 with dc_en=1, dc_freeze=1, rx_adc=12'h100: adc_out=0 two cycles after the first sample following the load, and stays 0.
- Saturation: load offset 16'h8000 (-32768), rx_adc=12'h7FF, dc_en=1, freeze=1: adc_out=16'h7FFF, not wrapped.
- Over-range: inject 5 samples of 12'h800 and 3 of 12'h7FF within one window (rest 0): rssi[31:16]=8 and rssi[15:0]=(5*2048+3*2047)>>10=15.
- Drop enable for 100 cycles mid-window, then reassert: adc_out=0 while low; the window completes after exactly 1024 enabled samples; reset pulse mid-window clears rssi and adc_out immediately.
